// File: rtl/filtro_convolucion_5x5.sv
// rtl/filtro_convolucion_5x5.sv - 5x5 weighted-sum filter: products, row sums, total, round/saturate.
// Four enabled stages with a lockstep valid bit; runtime-loadable signed coefficient bank.
module filtro_convolucion_5x5 #(
    parameter int BITS_PIXEL = 8,
    parameter int COEF_BITS  = 8,
    parameter int SHIFT      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  habilitador,
    input  logic                  valid_in,
    input  logic [BITS_PIXEL-1:0] pixel_1,
    input  logic [BITS_PIXEL-1:0] pixel_2,
    input  logic [BITS_PIXEL-1:0] pixel_3,
    input  logic [BITS_PIXEL-1:0] pixel_4,
    input  logic [BITS_PIXEL-1:0] pixel_5,
    input  logic [BITS_PIXEL-1:0] pixel_6,
    input  logic [BITS_PIXEL-1:0] pixel_7,
    input  logic [BITS_PIXEL-1:0] pixel_8,
    input  logic [BITS_PIXEL-1:0] pixel_9,
    input  logic [BITS_PIXEL-1:0] pixel_10,
    input  logic [BITS_PIXEL-1:0] pixel_11,
    input  logic [BITS_PIXEL-1:0] pixel_12,
    input  logic [BITS_PIXEL-1:0] pixel_13,
    input  logic [BITS_PIXEL-1:0] pixel_14,
    input  logic [BITS_PIXEL-1:0] pixel_15,
    input  logic [BITS_PIXEL-1:0] pixel_16,
    input  logic [BITS_PIXEL-1:0] pixel_17,
    input  logic [BITS_PIXEL-1:0] pixel_18,
    input  logic [BITS_PIXEL-1:0] pixel_19,
    input  logic [BITS_PIXEL-1:0] pixel_20,
    input  logic [BITS_PIXEL-1:0] pixel_21,
    input  logic [BITS_PIXEL-1:0] pixel_22,
    input  logic [BITS_PIXEL-1:0] pixel_23,
    input  logic [BITS_PIXEL-1:0] pixel_24,
    input  logic [BITS_PIXEL-1:0] pixel_25,
    input  logic                  coef_we,
    input  logic [4:0]            coef_addr,
    input  logic [COEF_BITS-1:0]  coef_data,
    output logic [BITS_PIXEL-1:0] pixel_out,
    output logic                  valid_out
);

    localparam int PW  = BITS_PIXEL + COEF_BITS + 1;
    localparam int ACC = BITS_PIXEL + COEF_BITS + 6;
    localparam logic [COEF_BITS-1:0] COEF_UNITY = COEF_BITS'(1 << SHIFT);
    // Half an LSB of the shifted result; collapses to zero when SHIFT is 0.
    localparam logic signed [ACC-1:0] ROUND   = ACC'((1 << SHIFT) >> 1);
    localparam logic signed [ACC-1:0] PIX_MAX = ACC'((1 << BITS_PIXEL) - 1);

    logic [BITS_PIXEL-1:0]        pix     [25];
    logic signed [COEF_BITS-1:0]  coef    [25];
    logic signed [PW-1:0]         prod_d  [25];
    logic signed [PW-1:0]         prod_q  [25];
    logic signed [ACC-1:0]        row_d   [5];
    logic signed [ACC-1:0]        row_q   [5];
    logic signed [ACC-1:0]        total_d;
    logic signed [ACC-1:0]        total_q;
    logic signed [ACC-1:0]        rounded;
    logic [BITS_PIXEL-1:0]        sat_d;
    logic [2:0]                   valid_q;

    assign pix[0]  = pixel_1;
    assign pix[1]  = pixel_2;
    assign pix[2]  = pixel_3;
    assign pix[3]  = pixel_4;
    assign pix[4]  = pixel_5;
    assign pix[5]  = pixel_6;
    assign pix[6]  = pixel_7;
    assign pix[7]  = pixel_8;
    assign pix[8]  = pixel_9;
    assign pix[9]  = pixel_10;
    assign pix[10] = pixel_11;
    assign pix[11] = pixel_12;
    assign pix[12] = pixel_13;
    assign pix[13] = pixel_14;
    assign pix[14] = pixel_15;
    assign pix[15] = pixel_16;
    assign pix[16] = pixel_17;
    assign pix[17] = pixel_18;
    assign pix[18] = pixel_19;
    assign pix[19] = pixel_20;
    assign pix[20] = pixel_21;
    assign pix[21] = pixel_22;
    assign pix[22] = pixel_23;
    assign pix[23] = pixel_24;
    assign pix[24] = pixel_25;

    // Bank writes ignore the pipeline enable so coefficients can be loaded during a stall.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 25; k++) begin
            if (reset) begin
                coef[k] <= (k == 12) ? COEF_UNITY : '0;
            end else if (coef_we && coef_addr == 5'(k)) begin
                coef[k] <= coef_data;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 25; k++) begin
            prod_d[k] = PW'($signed({1'b0, pix[k]})) * PW'(coef[k]);
        end
        for (int r = 0; r < 5; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < 5; c++) begin
                row_d[r] = row_d[r] + ACC'(prod_q[r*5+c]);
            end
        end
        total_d = '0;
        for (int r = 0; r < 5; r++) begin
            total_d = total_d + row_q[r];
        end
        rounded = (total_q + ROUND) >>> SHIFT;
        if (rounded < 0) begin
            sat_d = '0;
        end else if (rounded > PIX_MAX) begin
            sat_d = '1;
        end else begin
            sat_d = rounded[BITS_PIXEL-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 25; k++) prod_q[k] <= '0;
            for (int r = 0; r < 5; r++) row_q[r] <= '0;
            total_q   <= '0;
            pixel_out <= '0;
            valid_q   <= '0;
            valid_out <= 1'b0;
        end else if (habilitador) begin
            for (int k = 0; k < 25; k++) prod_q[k] <= prod_d[k];
            for (int r = 0; r < 5; r++) row_q[r] <= row_d[r];
            total_q   <= total_d;
            pixel_out <= sat_d;
            valid_q   <= {valid_q[1:0], valid_in};
            valid_out <= valid_q[2];
        end
    end

endmodule

// File: tb/tb_filtro_convolucion_5x5.sv
// tb/tb_filtro_convolucion_5x5.sv - randomized and directed bench with a scoreboard model.
module tb_filtro_convolucion_5x5;

    localparam int BP    = 8;
    localparam int CB    = 8;
    localparam int SHIFT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          habilitador = 1'b1;
    logic          valid_in = 1'b0;
    logic [BP-1:0] px [25];
    logic          coef_we = 1'b0;
    logic [4:0]    coef_addr = '0;
    logic [CB-1:0] coef_data = '0;
    logic [BP-1:0] pixel_out;
    logic          valid_out;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   m_coef [25];
    int   en_cnt = 0;
    bit   m_vld = 0;
    int   last_pix = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    filtro_convolucion_5x5 #(.BITS_PIXEL(BP), .COEF_BITS(CB), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .habilitador(habilitador), .valid_in(valid_in),
        .pixel_1(px[0]),   .pixel_2(px[1]),   .pixel_3(px[2]),   .pixel_4(px[3]),
        .pixel_5(px[4]),   .pixel_6(px[5]),   .pixel_7(px[6]),   .pixel_8(px[7]),
        .pixel_9(px[8]),   .pixel_10(px[9]),  .pixel_11(px[10]), .pixel_12(px[11]),
        .pixel_13(px[12]), .pixel_14(px[13]), .pixel_15(px[14]), .pixel_16(px[15]),
        .pixel_17(px[16]), .pixel_18(px[17]), .pixel_19(px[18]), .pixel_20(px[19]),
        .pixel_21(px[20]), .pixel_22(px[21]), .pixel_23(px[22]), .pixel_24(px[23]),
        .pixel_25(px[24]),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .pixel_out(pixel_out), .valid_out(valid_out)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pixel();
        int s = 0;
        for (int k = 0; k < 25; k++) s += int'(px[k]) * m_coef[k];
        if (SHIFT > 0) s += 1 << (SHIFT - 1);
        s = s >>> SHIFT;
        if (s < 0) return 0;
        if (s > (1 << BP) - 1) return (1 << BP) - 1;
        return s;
    endfunction

    function automatic void model_reset_coefs();
        for (int k = 0; k < 25; k++) m_coef[k] = (k == 12) ? (1 << SHIFT) : 0;
    endfunction

    // One clock: snapshot the driven inputs, advance the model, then check the outputs.
    task automatic tick();
        bit   r = reset;
        bit   h = habilitador;
        bit   v = valid_in;
        bit   we = coef_we;
        int   a = int'(coef_addr);
        int   d = int'($signed(coef_data));
        int   e = ref_pixel();
        exp_t it;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            model_reset_coefs();
            m_vld = 0;
            check("reset_pix", int'(pixel_out), 0);
            check("reset_vld", int'(valid_out), 0);
        end else begin
            if (h) begin
                en_cnt++;
                if (v) begin
                    it.val = e;
                    it.due = en_cnt + 3;
                    q.push_back(it);
                end
            end
            if (we && a < 25) m_coef[a] = d;
            if (!h) begin
                check("stall_vld", int'(valid_out), int'(m_vld));
                check("stall_pix", int'(pixel_out), last_pix);
            end else if (q.size() > 0 && q[0].due == en_cnt) begin
                m_vld = 1;
                check("out_vld", int'(valid_out), 1);
                check("out_pix", int'(pixel_out), q[0].val);
                void'(q.pop_front());
            end else begin
                m_vld = 0;
                check("bubble_vld", int'(valid_out), 0);
            end
        end
        last_pix = int'(pixel_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_coef(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = 5'(a);
        coef_data = CB'(d);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic fill_px(input int all_val, input int centre);
        for (int k = 0; k < 25; k++) px[k] = (all_val < 0) ? BP'($urandom) : BP'(all_val);
        px[12] = BP'(centre);
    endtask

    task automatic window(input int all_val, input int centre);
        fill_px(all_val, centre);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        fill_px(0, 0);
        model_reset_coefs();
        tick();
        do_reset();

        // Passthrough after reset.
        window(-1, 200);
        idle(6);

        // Box filter: 25 * 16 = 400 -> 25.
        for (int k = 0; k < 25; k++) set_coef(k, 1);
        window(16, 16);
        idle(5);

        // Saturation low and high.
        for (int k = 0; k < 25; k++) set_coef(k, (k == 12) ? -16 : 0);
        window(-1, 100);
        idle(5);
        for (int k = 0; k < 25; k++) set_coef(k, 16);
        window(255, 255);
        idle(5);

        // Stream of ten with a three-cycle stall after the fifth.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            window(-1, i);
            if (i == 5) begin
                habilitador = 1'b0;
                idle(3);
                habilitador = 1'b1;
            end
        end
        idle(6);

        // Coefficient write on the same edge as window A; B sees the new value.
        fill_px(0, 10);
        valid_in = 1'b1;
        coef_we = 1'b1;
        coef_addr = 5'd12;
        coef_data = 8'd32;
        tick();
        coef_we = 1'b0;
        window(0, 10);
        set_coef(27, 99);
        window(0, 10);
        idle(6);

        // Reset two cycles after a valid window discards it and restores passthrough.
        window(-1, 50);
        idle(1);
        do_reset();
        idle(5);
        window(-1, 77);
        idle(6);

        // Random traffic: enables, bubbles, writes (including bad addresses), rare resets.
        for (int i = 0; i < 600; i++) begin
            habilitador = ($urandom_range(0, 3) != 0);
            valid_in = $urandom_range(0, 1) == 1;
            coef_we = ($urandom_range(0, 4) == 0);
            coef_addr = 5'($urandom);
            coef_data = CB'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            fill_px(-1, $urandom_range(0, 255));
            tick();
        end
        reset = 1'b0;
        habilitador = 1'b1;
        valid_in = 1'b0;
        coef_we = 1'b0;
        idle(6);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
